// File: rtl/frontend_issue_buffer_if.sv
// Write-side and issue-side bus of frontend_issue_buffer.
// The buffer takes the slave modport and the fetch/backend side takes master.
interface frontend_issue_buffer_if #(
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned IN_PORT    = 2,
  parameter int unsigned OUT_PORT   = 2
);
  localparam int unsigned NUM_W = $clog2(IN_PORT + 1);

  logic                           write_ready_o;
  logic [NUM_W-1:0]               write_num_i;
  logic [IN_PORT*DATA_WIDTH-1:0]  write_data_i;
  logic [OUT_PORT-1:0]            out_valid_o;
  logic [OUT_PORT*DATA_WIDTH-1:0] out_data_o;
  logic [OUT_PORT-1:0]            issue_i;

  modport master (
    input  write_ready_o, out_valid_o, out_data_o,
    output write_num_i, write_data_i, issue_i
  );

  modport slave (
    output write_ready_o, out_valid_o, out_data_o,
    input  write_num_i, write_data_i, issue_i
  );
endinterface

// File: rtl/frontend_issue_buffer.sv
// In-order instruction ring plus registered issue window between decode and backend.
// Optional write-to-window bypass when the ring is empty: define ISSUE_BUF_BYPASS_EN.
module frontend_issue_buffer #(
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned IN_PORT    = 2,
  parameter int unsigned OUT_PORT   = 2,
  parameter int unsigned DEPTH      = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_i,
  input  logic                       hold_i,
  frontend_issue_buffer_if.slave     bus,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0]                mem [DEPTH];
  logic [PTR_W-1:0]                     head_q, tail_q;
  logic [CNT_W-1:0]                     count_q;
  logic                                 ready_q;
  logic [OUT_PORT-1:0]                  win_v_q, win_v_n;
  logic [OUT_PORT-1:0][DATA_WIDTH-1:0]  win_d_q, win_d_n;
  logic [IN_PORT-1:0][DATA_WIDTH-1:0]   wdata;

  int unsigned n_iss, n_val, retained, free_lanes, acc, byp, pops, cnt, count_n;

  assign wdata             = bus.write_data_i;
  assign bus.write_ready_o = ready_q;
  assign bus.out_valid_o   = win_v_q;
  assign bus.out_data_o    = win_d_q;
  assign count_o           = count_q;

  // Window retain/shift, bypass and ring refill for the coming edge
  always_comb begin
    n_iss = 0;
    n_val = 0;
    for (int unsigned j = 0; j < OUT_PORT; j++) begin
      n_iss += 32'(bus.issue_i[j]);
      n_val += 32'(win_v_q[j]);
    end
    retained   = (n_iss > n_val) ? 0 : n_val - n_iss;
    free_lanes = OUT_PORT - retained;
    cnt        = 32'(count_q);
    acc        = 0;
    if (ready_q) acc = (32'(bus.write_num_i) > IN_PORT) ? IN_PORT : 32'(bus.write_num_i);
    byp = 0;
`ifdef ISSUE_BUF_BYPASS_EN
    if (cnt == 0 && !hold_i) byp = (acc < free_lanes) ? acc : free_lanes;
`endif
    pops = 0;
    if (!hold_i) pops = (cnt < free_lanes - byp) ? cnt : free_lanes - byp;
    count_n = cnt + acc - byp - pops;

    for (int unsigned j = 0; j < OUT_PORT; j++) begin
      win_v_n[j] = 1'b0;
      win_d_n[j] = win_d_q[j];
      if (j < retained) begin
        win_v_n[j] = 1'b1;
        win_d_n[j] = win_d_q[j + n_iss];
      end
`ifdef ISSUE_BUF_BYPASS_EN
      else if (j < retained + byp) begin
        win_v_n[j] = 1'b1;
        win_d_n[j] = wdata[j - retained];
      end
`endif
      else if (j < retained + byp + pops) begin
        win_v_n[j] = 1'b1;
        win_d_n[j] = mem[PTR_W'(32'(head_q) + j - retained - byp)];
      end
    end
  end

  // Pointer, occupancy and window state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ready_q <= 1'b1;
      win_v_q <= '0;
      win_d_q <= '0;
    end else if (flush_i) begin
      head_q  <= tail_q;
      count_q <= '0;
      ready_q <= 1'b1;
      win_v_q <= '0;
    end else begin
      head_q  <= PTR_W'(32'(head_q) + pops);
      tail_q  <= PTR_W'(32'(tail_q) + acc - byp);
      count_q <= CNT_W'(count_n);
      ready_q <= (DEPTH - count_n) >= IN_PORT;
      win_v_q <= win_v_n;
      win_d_q <= win_d_n;
    end
  end

  // Ring storage; lanes already placed in the window by the bypass are skipped
  always_ff @(posedge clk) begin
    for (int unsigned k = 0; k < IN_PORT; k++) begin
      if (!flush_i && k >= byp && k < acc) mem[PTR_W'(32'(tail_q) + k - byp)] <= wdata[k];
    end
  end

  // issue_i must be a prefix mask inside the valid window
  always @(posedge clk) begin
    if (!rst) begin
      assert ((bus.issue_i & ~win_v_q) == '0);
      assert ((bus.issue_i & (bus.issue_i + OUT_PORT'(1))) == '0);
    end
  end
endmodule

// File: tb/tb_frontend_issue_buffer.sv
// Randomized and directed bench for frontend_issue_buffer against a queue-based model.
// Honors ISSUE_BUF_BYPASS_EN the same way the design does.
module tb_frontend_issue_buffer;
  localparam int unsigned DW  = 128;
  localparam int unsigned IN  = 2;
  localparam int unsigned OUT = 2;
  localparam int unsigned DEP = 16;
`ifdef ISSUE_BUF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush_i = 1'b0;
  logic hold_i = 1'b0;
  logic [$clog2(DEP+1)-1:0] count_o;

  frontend_issue_buffer_if #(.DATA_WIDTH(DW), .IN_PORT(IN), .OUT_PORT(OUT)) bus ();

  frontend_issue_buffer #(.DATA_WIDTH(DW), .IN_PORT(IN), .OUT_PORT(OUT), .DEPTH(DEP)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i), .hold_i(hold_i), .bus(bus), .count_o(count_o)
  );

  always #5 clk = ~clk;

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned seq   = 0;

  logic [DW-1:0] win_q [$];
  logic [DW-1:0] ring_q [$];
  bit            m_ready = 1'b1;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    logic [OUT-1:0] vmask;
    vmask = '0;
    for (int j = 0; j < win_q.size(); j++) vmask[j] = 1'b1;
    chk("valid", DW'(bus.out_valid_o), DW'(vmask));
    chk("count", DW'(count_o), DW'(ring_q.size()));
    chk("ready", DW'(bus.write_ready_o), DW'(m_ready));
    for (int j = 0; j < win_q.size(); j++)
      chk($sformatf("data%0d", j), bus.out_data_o[j*DW +: DW], win_q[j]);
  endtask

  // One clock: drive at negedge, advance model at posedge, check at next negedge
  task automatic step(input bit fl, input bit hd, input int unsigned wn, input int unsigned iss_n);
    logic [DW-1:0] lanes [IN];
    logic [OUT-1:0] iss;
    bit ring_empty;
    int unsigned acc;
    iss = '0;
    for (int j = 0; j < int'(iss_n); j++) iss[j] = 1'b1;
    for (int k = 0; k < int'(IN); k++) begin
      lanes[k] = {$urandom, $urandom, $urandom, seq};
      seq++;
      bus.write_data_i[k*DW +: DW] = lanes[k];
    end
    flush_i = fl;
    hold_i = hd;
    bus.write_num_i = 2'(wn);
    bus.issue_i = iss;
    @(posedge clk);
    if (fl) begin
      win_q.delete();
      ring_q.delete();
    end else begin
      ring_empty = (ring_q.size() == 0);
      acc = m_ready ? wn : 0;
      for (int j = 0; j < int'(iss_n); j++) void'(win_q.pop_front());
      if (!hd) while (win_q.size() < int'(OUT) && ring_q.size() > 0) win_q.push_back(ring_q.pop_front());
      for (int k = 0; k < int'(acc); k++) begin
        if (BYP && ring_empty && !hd && win_q.size() < int'(OUT)) win_q.push_back(lanes[k]);
        else ring_q.push_back(lanes[k]);
      end
    end
    m_ready = (DEP - ring_q.size()) >= IN;
    @(negedge clk);
    check_all();
  endtask

  initial begin
    bus.write_num_i = '0;
    bus.write_data_i = '0;
    bus.issue_i = '0;
    repeat (2) @(negedge clk);
    check_all();
    rst = 1'b0;
    @(negedge clk);
    check_all();

    // Two writes land in the window after the ring (or bypass) latency
    step(0, 0, 2, 0);
    step(0, 0, 0, 0);
    chk("first_pair", DW'(bus.out_valid_o), DW'(2'b11));

    // Fill until the ring refuses writes; further writes are dropped
    for (int i = 0; i < 14; i++) step(0, 0, 2, 0);
    chk("full_ready", DW'(bus.write_ready_o), '0);
    step(0, 0, 2, 0);
    step(0, 0, 1, 0);

    // Flush with a write and a partial issue in the same cycle
    step(1, 0, 2, 1);
    chk("flush_valid", DW'(bus.out_valid_o), '0);

    // Window {A,B}, ring {C,D}, then issue one lane
    step(0, 0, 2, 0);
    step(0, 0, 2, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    step(1, 0, 0, 0);

    // Hold drains the window without refill, release refills
    step(0, 0, 2, 0);
    step(0, 0, 2, 0);
    step(0, 0, 2, 0);
    step(0, 0, 0, 0);
    step(0, 1, 0, 2);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);

    // Partially issued window over an empty ring
    step(1, 0, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);

    // Random streaming with legal prefix issues, holds and rare flushes
    for (int i = 0; i < 600; i++)
      step(($urandom % 50) == 0, ($urandom % 8) == 0, $urandom % (IN + 1),
           $urandom_range(0, win_q.size()));

    // Asynchronous reset in the middle of traffic
    for (int i = 0; i < 6; i++) step(0, 0, 2, $urandom_range(0, win_q.size()));
    #2 rst = 1'b1;
    #1;
    win_q.delete();
    ring_q.delete();
    m_ready = 1'b1;
    check_all();
    bus.write_num_i = '0;
    bus.issue_i = '0;
    @(negedge clk);
    rst = 1'b0;
    step(0, 0, 2, 0);
    step(0, 0, 0, 0);
    for (int i = 0; i < 100; i++)
      step(1'b0, ($urandom % 6) == 0, $urandom % (IN + 1), $urandom_range(0, win_q.size()));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
